systolic_array_ctrl: RTL

- Sequencer for a ROWS x COLS weight-stationary systolic PE array: loads one weight tile, then streams activation vectors into the array rows with per-row skew.
- Collects the skewed bottom-row partial sums, deskews them into one aligned result vector per activation vector, and signals completion.
- Sits between the tile buffers (weight/activation streams) and the PE array; a single result consumer sits downstream.

---
 rtl/systolic_array_ctrl_pkg.sv | 22 ++
 rtl/systolic_array_ctrl_skew_delay_line.sv | 50 +++++
 rtl/systolic_array_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl_pkg
// Brief    : Shared widths and FSM state encodings for the systolic array
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_array_ctrl_pkg;

    localparam int SYSTOLIC_DATA_WIDTH = 8;
    localparam int SYSTOLIC_PSUM_WIDTH = 20;

    localparam int c_state_width = 3;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load_w = 3'd1;
    localparam logic [2:0] c_st_stream = 3'd2;
    localparam logic [2:0] c_st_drain  = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/systolic_array_ctrl_skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : skew_delay_line
// Brief    : Depth-N register chain carrying a valid bit and its data word.
//            DEPTH of zero is a straight wire.
// Revision : 1.0 - initial release
// ============================================================================
module skew_delay_line
    import systolic_array_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = SYSTOLIC_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_data  = i_data;
        end else begin : g_chain
            logic [DEPTH-1:0]            r_valid;
            logic [DEPTH-1:0][WIDTH-1:0] r_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    r_data  <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_data[0]  <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_data[i]  <= r_data[i-1];
                    end
                end
            end

            assign o_valid = r_valid[DEPTH-1];
            assign o_data  = r_data[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl
// Brief    : Weight-stationary systolic array sequencer: tile load, skewed
//            activation streaming and deskewed result collection.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = SYSTOLIC_DATA_WIDTH,
    parameter int PSUM_WIDTH = SYSTOLIC_PSUM_WIDTH,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                            s_clk,
    input  logic                            s_rst,
    input  logic                            start,
    input  logic [CNT_WIDTH-1:0]            cfg_num_vec,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic                            s_wgt_valid,
    output logic                            s_wgt_ready,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] s_wgt_data,
    input  logic                            s_act_valid,
    output logic                            s_act_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]      s_act_data,
    output logic                            pe_weight_valid,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] pe_weights,
    output logic [ROWS-1:0]                 pe_in_valid,
    output logic [ROWS*DATA_WIDTH-1:0]      pe_in_data,
    input  logic [COLS-1:0]                 pe_res_valid,
    input  logic [COLS*PSUM_WIDTH-1:0]      pe_res_psum,
    output logic                            m_res_valid,
    output logic [COLS*PSUM_WIDTH-1:0]      m_res_data
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    logic [c_state_width-1:0] r_state;
    logic [CNT_WIDTH-1:0]     r_num_vec;
    logic [CNT_WIDTH-1:0]     r_acc_cnt;
    logic [CNT_WIDTH-1:0]     r_res_cnt;

    logic                       w_start_ok;
    logic                       w_wgt_acc;
    logic                       w_act_acc;
    logic [CNT_WIDTH-1:0]       w_acc_next;
    logic [CNT_WIDTH-1:0]       w_res_next;
    logic [COLS-1:0]            w_col_valid;
    logic [COLS-1:0]            w_al_valid;
    logic [COLS*PSUM_WIDTH-1:0] w_al_psum;
    logic                       w_mismatch;
    logic                       w_idle_res;

    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign s_wgt_ready = (r_state == c_st_load_w);
    assign s_act_ready = (r_state == c_st_stream) && (r_acc_cnt < r_num_vec);

    assign w_start_ok = start && (r_state == c_st_idle);
    assign w_wgt_acc  = s_wgt_valid && s_wgt_ready;
    assign w_act_acc  = s_act_valid && s_act_ready;
    assign w_acc_next = r_acc_cnt + c_one;
    // Counting the result being emitted this cycle lets done follow it directly.
    assign w_res_next = m_res_valid ? (r_res_cnt + c_one) : r_res_cnt;

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state   <= c_st_idle;
            r_num_vec <= '0;
            r_acc_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state   <= c_st_load_w;
                        r_num_vec <= cfg_num_vec;
                        r_acc_cnt <= '0;
                    end
                end
                c_st_load_w: begin
                    if (w_wgt_acc) begin
                        r_state <= (r_num_vec == '0) ? c_st_done : c_st_stream;
                    end
                end
                c_st_stream: begin
                    if (w_act_acc) begin
                        r_acc_cnt <= w_acc_next;
                        if (w_acc_next == r_num_vec) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (w_res_next >= r_num_vec) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_res_cnt <= '0;
        end else if (w_start_ok) begin
            r_res_cnt <= '0;
        end else begin
            r_res_cnt <= w_res_next;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            pe_weight_valid <= 1'b0;
            pe_weights      <= '0;
        end else begin
            pe_weight_valid <= w_wgt_acc;
            if (w_wgt_acc) begin
                pe_weights <= s_wgt_data;
            end
        end
    end

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
            skew_delay_line #(
                .DEPTH (r + 1),
                .WIDTH (DATA_WIDTH)
            ) u_row_skew (
                .clk     (s_clk),
                .rst     (s_rst),
                .i_valid (w_act_acc),
                .i_data  (s_act_data[r*DATA_WIDTH +: DATA_WIDTH]),
                .o_valid (pe_in_valid[r]),
                .o_data  (pe_in_data[r*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Results seen while idle belong to no tile and are dropped at the input.
    assign w_col_valid = pe_res_valid & {COLS{r_state != c_st_idle}};

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col_deskew
            skew_delay_line #(
                .DEPTH (COLS - 1 - c),
                .WIDTH (PSUM_WIDTH)
            ) u_col_deskew (
                .clk     (s_clk),
                .rst     (s_rst),
                .i_valid (w_col_valid[c]),
                .i_data  (pe_res_psum[c*PSUM_WIDTH +: PSUM_WIDTH]),
                .o_valid (w_al_valid[c]),
                .o_data  (w_al_psum[c*PSUM_WIDTH +: PSUM_WIDTH])
            );
        end
    endgenerate

    assign w_mismatch = |(w_al_valid ^ {COLS{w_al_valid[COLS-1]}});
    assign w_idle_res = (r_state == c_st_idle) && (|pe_res_valid);

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            err         <= 1'b0;
            m_res_valid <= 1'b0;
            m_res_data  <= '0;
        end else begin
            if (w_start_ok) begin
                err <= 1'b0;
            end else if (w_mismatch || w_idle_res) begin
                err <= 1'b1;
            end
            m_res_valid <= w_al_valid[COLS-1];
            m_res_data  <= w_al_psum;
        end
    end

endmodule
`default_nettype wire
